// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RISC-V load/store funct3 codes
//   - 2-bit FSM state encoding
//   - size_bytes : access size code (funct3[1:0]) -> number of bytes
//   - byte_mask  : byte-lane mask of an access inside a doubleword
//   - expand_mask: byte-lane mask -> 64-bit bit mask
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // 1, 2, 4 or 8 bytes
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // Computed 16 bits wide so a doubleword access does not overflow before
    // the shift; only legal (in-doubleword) accesses are ever merged.
    function automatic logic [7:0] byte_mask(input logic [1:0] size,
                                             input logic [2:0] off);
        logic [15:0] m;
        m = ((16'd1 << size_bytes(size)) - 16'd1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] expand_mask(input logic [7:0] bm);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{bm[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Bundles the core request/response handshake and the data-memory port of
// the load/store unit.
//   slave  : the load/store unit side
//   master : the core + memory side (testbench / SoC glue)
// Core side : req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata,
//             resp_valid/resp_ready/resp_rdata/resp_error
// Memory    : Mem_Addr, Write_Data, MemWrite, MemRead, Read_Data
// ---------------------------------------------------------------------------
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Read_Data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  resp_ready, Read_Data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output Mem_Addr, Write_Data, MemWrite, MemRead
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output resp_ready, Read_Data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  Mem_Addr, Write_Data, MemWrite, MemRead
    );
endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational data path of the load/store unit.
//   i_rd         : doubleword read from memory
//   i_wdata      : right-aligned store data
//   i_funct3     : access type (size + sign)
//   i_offset     : byte offset inside the doubleword
//   o_load_data  : selected bytes, sign- or zero-extended
//   o_store_data : i_rd with the addressed bytes replaced by i_wdata
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_rd,
    input  logic [63:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic [2:0]  i_offset,
    output logic [63:0] o_load_data,
    output logic [63:0] o_store_data
);

    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic [63:0] w_mask;

    assign w_shamt   = {i_offset, 3'b000};
    assign w_shifted = i_rd >> w_shamt;
    assign w_mask    = expand_mask(byte_mask(i_funct3[1:0], i_offset));

    // Bring the addressed bytes down to bit 0, then extend by type
    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            F3_H:    o_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            F3_D:    o_load_data = w_shifted;
            F3_BU:   o_load_data = {56'd0, w_shifted[7:0]};
            F3_HU:   o_load_data = {48'd0, w_shifted[15:0]};
            F3_WU:   o_load_data = {32'd0, w_shifted[31:0]};
            default: o_load_data = '0;
        endcase
    end

    assign o_store_data = (i_rd & ~w_mask) | ((i_wdata << w_shamt) & w_mask);

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Multi-cycle load/store unit between the core and a 64-bit data memory.
// One request at a time; sub-doubleword stores are done as an aligned
// read-modify-write. Accesses crossing a doubleword boundary and illegal
// funct3 codes get an error response and never touch memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lsu_if.slave (core handshake + memory port)
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);

    lsu_state_t  r_state;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [2:0]  r_offset;
    logic [63:0] r_wdata;
    logic        r_resp_valid;
    logic        r_resp_error;
    logic [63:0] r_resp_rdata;
    logic [63:0] r_mem_addr;
    logic [63:0] r_write_data;
    logic        r_mem_write;
    logic        r_mem_read;

    logic [2:0]  w_offset;
    logic [3:0]  w_end;
    logic        w_req_error;
    logic        w_is_sd;
    logic [63:0] w_load_data;
    logic [63:0] w_store_data;

    // Offset + size fits in 4 bits (max 7 + 8); over 8 means the access
    // spills into the next doubleword.
    assign w_offset    = bus.req_addr[2:0];
    assign w_end       = {1'b0, w_offset} + size_bytes(bus.req_funct3[1:0]);
    assign w_req_error = (bus.req_funct3 == F3_ILL)
                       | (bus.req_write & bus.req_funct3[2])
                       | (w_end > 4'd8);
    assign w_is_sd     = bus.req_write & (bus.req_funct3 == F3_D);

    // Read_Data is only meaningful during RD, which is exactly when the
    // aligner outputs are consumed.
    lsu_align u_align (
        .i_rd         (bus.Read_Data),
        .i_wdata      (r_wdata),
        .i_funct3     (r_funct3),
        .i_offset     (r_offset),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data)
    );

    // FSM and all registered outputs. Full doubleword stores skip the read;
    // everything else that is legal goes through RD first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_funct3     <= '0;
            r_offset     <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_addr   <= '0;
            r_write_data <= '0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_write  <= bus.req_write;
                        r_funct3 <= bus.req_funct3;
                        r_offset <= w_offset;
                        r_wdata  <= bus.req_wdata;
                        if (w_req_error) begin
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                            r_resp_rdata <= '0;
                            r_state      <= ST_RESP;
                        end else if (w_is_sd) begin
                            r_mem_addr   <= {bus.req_addr[63:3], 3'b000};
                            r_write_data <= bus.req_wdata;
                            r_mem_write  <= 1'b1;
                            r_state      <= ST_WR;
                        end else begin
                            r_mem_addr <= {bus.req_addr[63:3], 3'b000};
                            r_mem_read <= 1'b1;
                            r_state    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    r_mem_read <= 1'b0;
                    if (r_write) begin
                        r_write_data <= w_store_data;
                        r_mem_write  <= 1'b1;
                        r_state      <= ST_WR;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_error <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_resp_rdata <= '0;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_error <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_error = r_resp_error;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.Mem_Addr   = r_mem_addr;
    assign bus.Write_Data = r_write_data;
    assign bus.MemWrite   = r_mem_write;
    assign bus.MemRead    = r_mem_read;

endmodule
